// File: rtl/operand_join.sv
// Pairs two independently buffered operand streams (A, B) for the adder-with-offset stage.
// Define OPERAND_JOIN_STATS_EN to add the PAIR_COUNT / STALL_COUNT statistics outputs.

module operand_join_fifo #(
  parameter int NBITS = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [NBITS-1:0] wdata_i,
  output logic [NBITS-1:0] head_o,
  output logic [AW:0]      level_o
);

  logic [NBITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;

  always_comb begin
    level_d = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + {{(AW-1){1'b0}}, 1'b1};
      if (pop_i)  rptr_q <= rptr_q + {{(AW-1){1'b0}}, 1'b1};
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    if (level_q != '0) head_o = mem_q[rptr_q];
    else               head_o = '0;
  end

  assign level_o = level_q;

endmodule

module operand_join #(
  parameter int NBITS = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NBITS-1:0]         A_DATA,
  input  logic                     A_VALID,
  output logic                     A_READY,
  input  logic [NBITS-1:0]         B_DATA,
  input  logic                     B_VALID,
  output logic                     B_READY,
  output logic [NBITS-1:0]         OUT_A,
  output logic [NBITS-1:0]         OUT_B,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [$clog2(DEPTH):0]   A_LEVEL,
  output logic [$clog2(DEPTH):0]   B_LEVEL
`ifdef OPERAND_JOIN_STATS_EN
  ,
  output logic [15:0]              PAIR_COUNT,
  output logic [15:0]              STALL_COUNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic push_a_s;
  logic push_b_s;
  logic pop_s;

  assign A_READY   = (A_LEVEL != FULL_LVL);
  assign B_READY   = (B_LEVEL != FULL_LVL);
  assign push_a_s  = A_VALID && A_READY;
  assign push_b_s  = B_VALID && B_READY;
  assign OUT_VALID = (A_LEVEL != '0) && (B_LEVEL != '0);
  // Both sides pop together so the k-th A always meets the k-th B.
  assign pop_s     = OUT_VALID && OUT_READY;

  operand_join_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_fifo_a (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_a_s),
    .pop_i   (pop_s),
    .wdata_i (A_DATA),
    .head_o  (OUT_A),
    .level_o (A_LEVEL)
  );

  operand_join_fifo #(.NBITS(NBITS), .DEPTH(DEPTH)) u_fifo_b (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push_b_s),
    .pop_i   (pop_s),
    .wdata_i (B_DATA),
    .head_o  (OUT_B),
    .level_o (B_LEVEL)
  );

`ifdef OPERAND_JOIN_STATS_EN
  logic [15:0] pair_cnt_q;
  logic [15:0] stall_cnt_q;

  // Pair count wraps; stall count saturates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pair_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (pop_s) pair_cnt_q <= pair_cnt_q + 16'd1;
      if (OUT_VALID && !OUT_READY && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign PAIR_COUNT  = pair_cnt_q;
  assign STALL_COUNT = stall_cnt_q;
`endif

endmodule

// File: doc/operand_join.md
Name: operand_join

Overview:
- Upstream feeder for the adder-with-offset stage.
- Accepts two independent operand streams (A, B), each with a valid/ready handshake, and buffers each stream in its own FIFO.
- Presents matched operand pairs (IN_A/IN_B source) to the downstream stage under a single valid/ready handshake.
- Decouples producers of A and B so they may run at different rates.

Parameters:
- NBITS, 8, operand width in bits.
- DEPTH, 4, entries per operand FIFO; power of 2, minimum 2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- A_DATA  input  NBITS  operand A payload.
- A_VALID  input  1  A_DATA valid.
- A_READY  output  1  A FIFO can accept.
- B_DATA  input  NBITS  operand B payload.
- B_VALID  input  1  B_DATA valid.
- B_READY  output  1  B FIFO can accept.
- OUT_A  output  NBITS  head of A FIFO; drives downstream IN_A.
- OUT_B  output  NBITS  head of B FIFO; drives downstream IN_B.
- OUT_VALID  output  1  a matched pair is presented.
- OUT_READY  input  1  downstream consumes the pair.
- A_LEVEL  output  clog2(DEPTH)+1  A FIFO occupancy.
- B_LEVEL  output  clog2(DEPTH)+1  B FIFO occupancy.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Read/write pointers and levels clear to 0.
  - A_READY=B_READY=1 and OUT_VALID=0 from the first cycle after reset.
  - OUT_A/OUT_B=0.
- RST has priority over every simultaneous push and pop. Reset mid-operation discards all buffered data, and handshakes in that cycle are not counted.
- Per-side FIFO:
  - A_READY = (A_LEVEL != DEPTH); B_READY likewise.
  - Push A when A_VALID && A_READY; push B likewise.
  - No push-through when full: READY depends on full only, never on OUT_READY.
- Pairing:
  - OUT_VALID = (A_LEVEL != 0) && (B_LEVEL != 0).
  - Pop fires when OUT_VALID && OUT_READY; it removes exactly one entry from each FIFO in the same cycle.
  - A side is never popped alone.
- Output data:
  - First-word fall-through: OUT_A/OUT_B show the FIFO heads combinationally from storage registers.
  - Heads are 0 when the FIFO is empty.
  - OUT_A/OUT_B are stable while OUT_VALID=1 and OUT_READY=0.
- Latency: an item pushed at edge N is visible at the head after edge N. OUT_VALID rises in the cycle after the later of the two pushes. Minimum latency is 1 cycle.
- Throughput: 1 pair/cycle when both producers and the consumer stream continuously.
- Simultaneous push and pop on one side: level unchanged, both pointers advance.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Levels are kept as explicit counters (0..DEPTH); they do not wrap.
- Ordering: the k-th accepted A is always paired with the k-th accepted B.
- Data is passed unmodified; no arithmetic in this block.

Optional Feature:
- Macro OPERAND_JOIN_STATS_EN.
- When defined:
  - Adds output PAIR_COUNT [15:0], which increments on each pop, wraps 0xFFFF->0, and clears on RST.
  - Adds output STALL_COUNT [15:0], which increments each cycle OUT_VALID && !OUT_READY, saturates at 0xFFFF, and clears on RST.
- When undefined: neither port nor its counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then push A=0x10 and B=0x20 on the same cycle with OUT_READY=1 -> one cycle later OUT_VALID=1, OUT_A=0x10, OUT_B=0x20; pop; next cycle OUT_VALID=0 and both levels 0.
- Skewed arrival: push A=0x01,0x02,0x03 with no B; then push B=0xA1,0xA2,0xA3 -> pairs emitted in order (0x01,0xA1),(0x02,0xA2),(0x03,0xA3); A_LEVEL peaks at 3.
- Full: hold OUT_READY=0 and push 4 A values -> A_READY=0 after the 4th; a 5th A_VALID is not accepted; A_LEVEL=4. Then push B and release OUT_READY -> 4 pairs, A_READY returns to 1.
- Backpressure: pair (0x55,0xAA) presented with OUT_READY=0 for 5 cycles -> OUT_A/OUT_B stable; with STATS_EN, STALL_COUNT=5.
- Streaming plus wrap: 20 consecutive cycles of both pushes with OUT_READY=1 (values 0..19) -> 20 in-order pairs, no bubbles after the first, pointers wrap 5 times; with STATS_EN, PAIR_COUNT=20.
- Reset mid-operation: 3 A and 1 B buffered, assert RST for one cycle while A_VALID=1 -> levels 0, OUT_VALID=0; the next pushed pair (0x7F,0x01) emerges first.
